fp_add_sequencer: RTL and testbench
===================================

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 SHALL have one parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts an operand pair.
REQ-006 SHALL have ports in_a and in_b, input, 32 each, IEEE-754 single-precision operands.
REQ-007 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-009 SHALL have port out_sum, output, 32, the single-precision sum.
REQ-010 SHALL have port out_ovf, output, 1, the exponent-overflow flag.
REQ-011 SHALL have port out_nan, output, 1, the NaN-input flag.
REQ-012 SHALL have port op_count, output, CNT_W, the number of completed results.

Function
REQ-013 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE, advancing one state per cycle IDLE->ALIGN->ADD->NORM->DONE.
REQ-014 SHALL drive in_ready high only in IDLE; an accept is in_valid && in_ready at a rising edge, which latches in_a/in_b and enters ALIGN.
REQ-015 SHALL assert out_valid in DONE only, 4 edges after the accepting edge, so throughput is 1 result per 5 cycles minimum.
REQ-016 SHALL hold out_sum, out_ovf and out_nan stable while out_valid && !out_ready, and return to IDLE on the edge where out_valid && out_ready.
REQ-017 ALIGN SHALL swap operands so A has the larger magnitude ({exp, mant} compare), SHALL prepend the hidden 1 to the mantissa, and SHALL right-shift B's mantissa by the exponent difference.
REQ-018 When the exponent difference is >= 25, ALIGN SHALL treat B's contribution as zero.
REQ-019 ADD SHALL add the 24-bit mantissas when signs are equal and SHALL subtract B from A otherwise, producing a 24-bit result plus a carry.
REQ-020 NORM SHALL, when carry is set, shift right by 1 and increment the exponent; otherwise it SHALL left-shift to the leading one and decrement the exponent by the leading-zero count.
REQ-021 Rounding SHALL be truncation; discarded bits SHALL be dropped.
REQ-022 The sign SHALL be A's sign after the swap; an exact cancellation (zero mantissa) SHALL give +0 (0x00000000).
REQ-023 An operand with exponent 0 SHALL be treated as zero (denormals flushed); a normalized exponent <= 0 SHALL yield signed zero.
REQ-024 A normalized exponent >= 255 SHALL yield signed infinity (exp 0xFF, mant 0) with out_ovf=1.
REQ-025 Any operand with exponent 255 SHALL yield 0x7FC00000 with out_nan=1 and out_ovf=0.
REQ-026 op_count SHALL increment by 1 on each out handshake and SHALL wrap modulo 2^CNT_W.
REQ-027 in_valid arriving in any state other than IDLE SHALL be ignored; no input skid buffer is provided.

Reset
REQ-028 On rst high, the block SHALL immediately force IDLE with in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_nan=0 and op_count=0.
REQ-029 An operation in flight at reset SHALL be discarded without producing a result or incrementing op_count.

Structure
REQ-030 A shared package fp_pkg SHALL hold the state enum, the constants EXP_W=8, MANT_W=23, EXP_MAX=255 and QNAN=32'h7FC00000, and a packed fp32 struct {sign, exp, mant}.
REQ-031 The leading-one detect and shift of NORM SHALL be a combinational sub-module fp_norm_shift (inputs: 24-bit mantissa and carry; outputs: 23-bit fraction and a signed 8-bit exponent adjust).

Verification
REQ-032 The bench SHALL check 0x3F800000 + 0x3F800000 -> 0x40000000, with out_valid 4 edges after accept and op_count=1.
REQ-033 The bench SHALL check 0x40400000 + 0xBF800000 -> 0x40000000 and 0x3FC00000 + 0xBFC00000 -> 0x00000000.
REQ-034 The bench SHALL check 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with out_ovf=1, and 0x7F800000 + 0x3F800000 -> 0x7FC00000 with out_nan=1.
REQ-035 The bench SHALL hold out_ready low for 3 cycles in DONE and require out_sum stable, in_ready=0 and in_valid ignored throughout.
REQ-036 The bench SHALL assert rst during ADD and require IDLE, out_valid=0 and op_count=0 immediately, with the next operation correct.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// fp_pkg : shared state encoding, constants and fp32 type for the adder (rev 1.0)
//----------------------------------------------------------------------------
package fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MANT_W  = 23;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage
`default_nettype wire

// File: rtl/fp_norm_shift.sv
`default_nettype none
//----------------------------------------------------------------------------
// fp_norm_shift : leading-one detect and normalising shift of a raw sum (rev 1.0)
//----------------------------------------------------------------------------
module fp_norm_shift (
  input  logic [23:0]       mant,
  input  logic              carry,
  output logic [22:0]       frac,
  output logic signed [7:0] exp_adj
);

  logic [4:0]  lzc;
  logic        found;
  logic [22:0] shifted;

  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && mant[i]) begin
        lzc   = 5'(23 - i);
        found = 1'b1;
      end
    end
    // Shifted-out leading one becomes the hidden bit and is not stored.
    shifted = 23'(mant << lzc);
    if (carry) begin
      frac    = mant[23:1];
      exp_adj = 8'sd1;
    end else begin
      frac    = shifted;
      exp_adj = -$signed({3'b000, lzc});
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------------
// fp_add_sequencer : multi-cycle truncating fp32 adder with valid/ready (rev 1.0)
//----------------------------------------------------------------------------
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic             out_nan,
  output logic [CNT_W-1:0] op_count
);

  localparam logic signed [9:0] EXP_LIMIT = 10'(EXP_MAX);
  localparam logic [EXP_W-1:0]  EXP_ONES  = EXP_W'(EXP_MAX);

  state_t           state;
  fp32_t            op_a;
  fp32_t            op_b;
  logic [EXP_W-1:0] big_exp;
  logic [23:0]      big_mant;
  logic [23:0]      small_mant;
  logic [23:0]      sum_mant;
  logic             sum_carry;
  logic             res_sign;
  logic             do_sub;
  logic             is_nan;

  logic [30:0]      key_a;
  logic [30:0]      key_b;
  logic [30:0]      key_big;
  logic [30:0]      key_small;
  logic             swap;
  logic [EXP_W-1:0] exp_diff;
  logic [23:0]      big_full;
  logic [23:0]      small_full;
  logic [23:0]      small_aligned;

  // Zero-exponent operands are flushed to a zero key before ordering.
  always_comb begin
    key_a         = (op_a.exp == 8'd0) ? 31'd0 : {op_a.exp, op_a.mant};
    key_b         = (op_b.exp == 8'd0) ? 31'd0 : {op_b.exp, op_b.mant};
    swap          = key_b > key_a;
    key_big       = swap ? key_b : key_a;
    key_small     = swap ? key_a : key_b;
    big_full      = {key_big[30:23] != 8'd0, key_big[22:0]};
    small_full    = {key_small[30:23] != 8'd0, key_small[22:0]};
    exp_diff      = key_big[30:23] - key_small[30:23];
    small_aligned = (exp_diff >= 8'd25) ? 24'd0 : (small_full >> exp_diff);
  end

  logic [24:0] sum_ext;

  always_comb begin
    if (do_sub) begin
      sum_ext = {1'b0, big_mant} - {1'b0, small_mant};
    end else begin
      sum_ext = {1'b0, big_mant} + {1'b0, small_mant};
    end
  end

  logic [22:0]       norm_frac;
  logic signed [7:0] norm_adj;
  logic signed [9:0] norm_exp;
  logic [31:0]       norm_sum;
  logic              norm_ovf;

  fp_norm_shift u_norm_shift (
    .mant    (sum_mant),
    .carry   (sum_carry),
    .frac    (norm_frac),
    .exp_adj (norm_adj)
  );

  always_comb begin
    norm_exp = $signed({2'b00, big_exp}) + $signed({{2{norm_adj[7]}}, norm_adj});
    norm_ovf = 1'b0;
    if (!sum_carry && (sum_mant == 24'd0)) begin
      norm_sum = 32'd0;
    end else if (norm_exp >= EXP_LIMIT) begin
      norm_sum = {res_sign, EXP_ONES, 23'd0};
      norm_ovf = 1'b1;
    end else if (norm_exp <= 10'sd0) begin
      norm_sum = {res_sign, 31'd0};
    end else begin
      norm_sum = {res_sign, norm_exp[7:0], norm_frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sum    <= 32'd0;
      out_ovf    <= 1'b0;
      out_nan    <= 1'b0;
      op_count   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      big_exp    <= '0;
      big_mant   <= '0;
      small_mant <= '0;
      sum_mant   <= '0;
      sum_carry  <= 1'b0;
      res_sign   <= 1'b0;
      do_sub     <= 1'b0;
      is_nan     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          big_exp    <= key_big[30:23];
          big_mant   <= big_full;
          small_mant <= small_aligned;
          res_sign   <= swap ? op_b.sign : op_a.sign;
          do_sub     <= op_a.sign ^ op_b.sign;
          is_nan     <= (op_a.exp == EXP_ONES) || (op_b.exp == EXP_ONES);
          state      <= ADD;
        end
        ADD: begin
          {sum_carry, sum_mant} <= sum_ext;
          state                 <= NORM;
        end
        NORM: begin
          out_sum   <= is_nan ? QNAN : norm_sum;
          out_ovf   <= !is_nan && norm_ovf;
          out_nan   <= is_nan;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_count  <= op_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_fp_add_sequencer : directed self-checking bench for fp_add_sequencer (rev 1.0)
//----------------------------------------------------------------------------
module tb_fp_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        out_nan;
  logic [15:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int ops_done = 0;

  fp_add_sequencer #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Returns {nan, ovf, sum}: align by truncating shift, integer add, renormalise.
  function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, d, e, ti;
    longint ma, mb, s, tl;
    logic   sa, sb, tb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {2'b10, 32'h7FC0_0000};
    ma = (ea == 0) ? 64'd0 : {40'd0, 1'b1, a[22:0]};
    mb = (eb == 0) ? 64'd0 : {40'd0, 1'b1, b[22:0]};
    sa = a[31];
    sb = b[31];
    if (eb > ea || (eb == ea && mb > ma)) begin
      ti = ea; ea = eb; eb = ti;
      tl = ma; ma = mb; mb = tl;
      tb = sa; sa = sb; sb = tb;
    end
    d  = ea - eb;
    mb = (d >= 25) ? 64'd0 : (mb >> d);
    s  = (sa == sb) ? ma + mb : ma - mb;
    if (s == 0) return 34'd0;
    e = ea;
    while (s >= (64'd1 << 24)) begin s = s >> 1; e = e + 1; end
    while (s <  (64'd1 << 23)) begin s = s << 1; e = e - 1; end
    if (e >= 255) return {2'b01, sa, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b00, sa, 31'd0};
    return {2'b00, sa, e[7:0], s[22:0]};
  endfunction

  // Reference of the handshake behaviour: age counts edges since acceptance.
  logic        busy;
  int          age;
  int          exp_count;
  logic [33:0] q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      age       <= 0;
      exp_count <= 0;
      q.delete();
    end else if (!busy) begin
      if (in_valid) begin
        busy <= 1'b1;
        age  <= 0;
        q.push_back(model_add(in_a, in_b));
      end
    end else if (age < 3) begin
      age <= age + 1;
    end else if (out_ready) begin
      busy      <= 1'b0;
      exp_count <= exp_count + 1;
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready vs model", in_ready, !busy);
      check("out_valid vs model", out_valid, busy && (age == 3));
      check("op_count vs model", op_count, 16'(exp_count));
      if (busy && age == 3) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL result vs model: actual=%h required=<queued result>", out_sum);
        end else begin
          check("result vs model", {out_nan, out_ovf, out_sum}, q[0]);
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_sum,
                        input logic exp_ovf, input logic exp_nan, input int hold, input logic keep);
    int          lat;
    int          guard;
    logic [31:0] held;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready wait: actual=0 required=1");
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (keep) begin in_a = $urandom; in_b = $urandom; end
    else in_valid = 1'b0;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (keep) begin in_a = $urandom; in_b = $urandom; end
    end
    // Edges counted include the accepting edge itself.
    check("latency edges", lat, 4);
    if (!out_valid) return;
    check("out_sum", out_sum, exp_sum);
    check("out_ovf", out_ovf, exp_ovf);
    check("out_nan", out_nan, exp_nan);
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("held out_sum", out_sum, held);
      check("held out_valid", out_valid, 1'b1);
      check("held in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    ops_done++;
    check("op_count after handshake", op_count, ops_done);
    check("out_valid after handshake", out_valid, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_sum", out_sum, 32'd0);
    check("reset out_ovf", out_ovf, 1'b0);
    check("reset out_nan", out_nan, 1'b0);
    check("reset op_count", op_count, 16'd0);

    check("model 1+1", model_add(32'h3F80_0000, 32'h3F80_0000), {2'b00, 32'h4000_0000});
    check("model 3-1", model_add(32'h4040_0000, 32'hBF80_0000), {2'b00, 32'h4000_0000});
    check("model max+max", model_add(32'h7F7F_FFFF, 32'h7F7F_FFFF), {2'b01, 32'h7F80_0000});
    check("model inf+1", model_add(32'h7F80_0000, 32'h3F80_0000), {2'b10, 32'h7FC0_0000});
    rst = 1'b0;

    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 0, 1'b0);
    run_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 3, 1'b1);
    run_op(32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'h80C0_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b0);

    // Abort an operation while it sits in ADD.
    in_valid = 1'b1;
    in_a     = 32'h4040_0000;
    in_b     = 32'h3F80_0000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort in_ready", in_ready, 1'b1);
    check("abort out_valid", out_valid, 1'b0);
    check("abort op_count", op_count, 16'd0);
    check("abort out_sum", out_sum, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    ops_done = 0;
    repeat (5) @(negedge clk);
    check("no result after abort", out_valid, 1'b0);
    run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
